// File: rtl/hole_pkg.sv
// Shared types and constants for the hole/pocket detection slice.
package hole_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ENTERING = 2'd1,
    POCKETED = 2'd2
  } ball_state_t;

  localparam int unsigned CNT_W                     = 10;
  localparam logic [7:0]  TRANSPARENT_ENCODING      = 8'hFF;
  localparam int unsigned DEFAULT_OVERLAP_THRESHOLD = 16;
  localparam int unsigned DEFAULT_CONSEC_FRAMES     = 2;

endpackage

// File: rtl/pocket_tracker.sv
// Per-ball overlap accumulator and FREE/ENTERING/POCKETED state machine,
// evaluated once per frame on the start-of-frame pulse.
module pocket_tracker
  import hole_pkg::*;
#(
  parameter int unsigned OVERLAP_THRESHOLD = DEFAULT_OVERLAP_THRESHOLD,
  parameter int unsigned CONSEC_FRAMES     = DEFAULT_CONSEC_FRAMES
) (
  input  logic clk,
  input  logic reset,
  input  logic start_of_frame,
  input  logic overlap,
  input  logic clear,
  output logic pocket_pulse,
  output logic pocketed
);

  localparam int unsigned FRM_W = (CONSEC_FRAMES > 1) ? $clog2(CONSEC_FRAMES + 1) : 1;

  ball_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [FRM_W-1:0] frm, frm_n, frm_inc;
  logic             pulse_n, pocketed_n;
  logic             qualify;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FREE;
      cnt          <= '0;
      frm          <= '0;
      pocket_pulse <= 1'b0;
      pocketed     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      frm          <= frm_n;
      pocket_pulse <= pulse_n;
      pocketed     <= pocketed_n;
    end
  end

  // The start-of-frame pixel belongs to the new frame: evaluate the old count,
  // then reload with this cycle's overlap.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    frm_n      = frm;
    pulse_n    = 1'b0;
    pocketed_n = pocketed;
    qualify    = 32'(cnt) >= OVERLAP_THRESHOLD;
    frm_inc    = frm + FRM_W'(1);

    if (clear) begin
      state_n    = FREE;
      cnt_n      = '0;
      frm_n      = '0;
      pocketed_n = 1'b0;
    end else if (start_of_frame) begin
      cnt_n = {{(CNT_W-1){1'b0}}, overlap};
      unique case (state)
        FREE: begin
          if (qualify) begin
            if (CONSEC_FRAMES <= 1) begin
              state_n    = POCKETED;
              pulse_n    = 1'b1;
              pocketed_n = 1'b1;
            end else begin
              state_n = ENTERING;
            end
            frm_n = FRM_W'(1);
          end
        end
        ENTERING: begin
          if (qualify) begin
            frm_n = frm_inc;
            if (32'(frm_inc) >= CONSEC_FRAMES) begin
              state_n    = POCKETED;
              pulse_n    = 1'b1;
              pocketed_n = 1'b1;
            end
          end else begin
            state_n = FREE;
            frm_n   = '0;
          end
        end
        POCKETED: state_n = POCKETED;
        default: begin
          state_n = FREE;
          frm_n   = '0;
        end
      endcase
    end else if (overlap && (cnt != '1)) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hole_pocket_detector.sv
// Detects balls falling into a hole from per-pixel layer overlap and keeps a
// saturating count of pocket events.
module hole_pocket_detector
  import hole_pkg::*;
#(
  parameter int unsigned NUM_BALLS         = 4,
  parameter int unsigned OVERLAP_THRESHOLD = DEFAULT_OVERLAP_THRESHOLD,
  parameter int unsigned CONSEC_FRAMES     = DEFAULT_CONSEC_FRAMES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 drawingRequestHole,
  input  logic [NUM_BALLS-1:0] drawingRequestBalls,
  input  logic                 clearPocketed,
  output logic [NUM_BALLS-1:0] pocketPulse,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic [3:0]           pocketCount
);

  logic [7:0] pulse_pop;
  logic [8:0] count_sum;
  logic [3:0] count_n;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    pocket_tracker #(
      .OVERLAP_THRESHOLD(OVERLAP_THRESHOLD),
      .CONSEC_FRAMES    (CONSEC_FRAMES)
    ) u_tracker (
      .clk           (clk),
      .reset         (reset),
      .start_of_frame(startOfFrame),
      .overlap       (drawingRequestHole & drawingRequestBalls[g]),
      .clear         (clearPocketed),
      .pocket_pulse  (pocketPulse[g]),
      .pocketed      (pocketedMask[g])
    );
  end

  always_comb begin
    pulse_pop = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      pulse_pop = pulse_pop + 8'(pocketPulse[i]);
    end
    count_sum = {5'd0, pocketCount} + {1'b0, pulse_pop};
    count_n   = (count_sum > 9'd15) ? 4'hF : count_sum[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pocketCount <= '0;
    end else begin
      pocketCount <= count_n;
    end
  end

endmodule

// File: doc/hole_pocket_detector.md
HOLE_POCKET_DETECTOR -- requirements
Module: hole_pocket_detector

Interface
REQ-001 The block SHALL have parameter NUM_BALLS, default 4, giving the number of balls tracked.
REQ-002 The block SHALL have parameter OVERLAP_THRESHOLD, default 16, giving the minimum ball/hole overlap pixels per frame.
REQ-003 The block SHALL have parameter CONSEC_FRAMES, default 2, giving the number of consecutive qualifying frames needed to pocket a ball.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port startOfFrame, input, 1 bit: one-cycle pulse on the first pixel of a frame.
REQ-007 The block SHALL have port drawingRequestHole, input, 1 bit: the registered hole layer request.
REQ-008 The block SHALL have port drawingRequestBalls, input, NUM_BALLS bits: per-ball request, cycle-aligned with drawingRequestHole.
REQ-009 The block SHALL have port clearPocketed, input, 1 bit: one-cycle pulse that returns all balls to the on-table state (new rack).
REQ-010 The block SHALL have port pocketPulse, output, NUM_BALLS bits: one-cycle pulse per ball when that ball is pocketed.
REQ-011 The block SHALL have port pocketedMask, output, NUM_BALLS bits: sticky set of pocketed balls.
REQ-012 The block SHALL have port pocketCount, output, 4 bits: total pocket events, saturating at 15.

Function
REQ-013 Each ball SHALL own an overlap counter, CNT_W=10 bits, that increments on every cycle where drawingRequestHole and that ball's request bit are both 1, and saturates at 1023.
REQ-014 On a startOfFrame cycle, the counter SHALL be evaluated using the value accumulated before that cycle, then reload to 1 if that cycle overlaps and to 0 otherwise.
REQ-015 Each ball SHALL have an FSM with states FREE, ENTERING and POCKETED, updated only on startOfFrame cycles, except for clearPocketed.
REQ-016 In FREE, a counter value of at least OVERLAP_THRESHOLD SHALL load the frame counter with 1 and move the FSM to ENTERING; otherwise the FSM stays in FREE.
REQ-017 In ENTERING, a qualifying frame SHALL increment the frame counter, and when the frame counter reaches CONSEC_FRAMES the FSM SHALL move to POCKETED.
REQ-018 In ENTERING, a non-qualifying frame SHALL return the FSM to FREE with the frame counter cleared.
REQ-019 With CONSEC_FRAMES=1, the transition SHALL go FREE -> POCKETED directly.
REQ-020 On entry to POCKETED, pocketPulse[i] SHALL be 1 for exactly the cycle after the startOfFrame cycle, and pocketedMask[i] SHALL be set in the same cycle.
REQ-021 In POCKETED, overlap SHALL be ignored and no further pulses SHALL be produced.
REQ-022 pocketCount SHALL add the number of pocketPulse bits asserted in a cycle, handling simultaneous pulses from several balls, and saturate at 15.
REQ-023 clearPocketed SHALL, on the next edge, move all FSMs to FREE, zero the overlap and frame counters, clear pocketedMask, and hold pocketCount.
REQ-024 If clearPocketed coincides with startOfFrame, clear SHALL win: no evaluation and no pulse that frame.
REQ-025 The first startOfFrame after reset SHALL evaluate a count accumulated over a partial frame; this is accepted behaviour.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset SHALL asynchronously force all FSMs to FREE, all counters to 0, pocketPulse to 0, pocketedMask to 0 and pocketCount to 0.
REQ-028 Reset asserted mid-frame SHALL discard any partial accumulation, and the first post-reset startOfFrame SHALL evaluate from 0.

Structure
REQ-029 Package hole_pkg SHALL hold the FSM state enum, CNT_W, the TRANSPARENT_ENCODING constant (8'hFF), and the default threshold and frame constants.
REQ-030 The per-ball counter and FSM SHALL be the sub-module pocket_tracker, generate-instantiated NUM_BALLS times.
REQ-031 The top level SHALL hold the pocketCount adder and the input fan-out only.

Verification
REQ-032 Ball 0 overlaps 20 pixels in each of frames 1 and 2 -> pocketPulse=4'b0001 for one cycle after the frame-3 startOfFrame, pocketedMask=4'b0001, pocketCount=1.
REQ-033 Ball 1 overlaps 20 pixels in frame 1 and 15 pixels in frame 2 -> no pulse; the FSM returns to FREE at the frame-3 startOfFrame.
REQ-034 Balls 2 and 3 each overlap 30 pixels for 2 frames -> pocketPulse=4'b1100 in a single cycle, and pocketCount increments by 2.
REQ-035 Overlap asserted exactly on the startOfFrame cycle -> that pixel counts toward the new frame; 15 prior pixels plus 1 on the startOfFrame cycle does not qualify the old frame.
REQ-036 clearPocketed coincident with a qualifying startOfFrame -> no pulse, mask=0, counts=0; then 18 pocket events -> pocketCount saturates at 15.
REQ-037 Reset pulsed mid-frame after 12 overlap pixels, then 10 more pixels before startOfFrame -> no ENTERING transition, and all outputs are 0 while reset is high.
